// File: rtl/pixel_ram_arbiter.sv
// pixel_ram_arbiter
// Time-multiplexes the single-port pixel RAM between the pixel writer and the
// window reader. All traffic is held off until the clock generator's lock has
// been stable for LOCK_HOLD cycles. Writes have priority, but a pending read
// is never passed over more than STARVE_MAX times in a row.
//
// Ports
//   mainClk, resetN          : clock, asynchronous active-low reset
//   locked                   : clock-generator lock (asynchronous, synchronized here)
//   ready                    : arbiter is running and may grant accesses
//   wrReq/wrAddr/wrData/wrAck: writer handshake (ack is combinational)
//   rdReq/rdAddr/rdAck       : reader handshake (ack is combinational)
//   rdValid/rdData           : read return, two cycles after rdAck
//   memEn/memWe/memAddr/memWdata/memRdata : registered RAM command, RAM read data
module pixel_ram_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LOCK_HOLD  = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              mainClk,
    input  logic              resetN,
    input  logic              locked,
    output logic              ready,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrAck,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdAck,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int unsigned HOLD_W   = $clog2(LOCK_HOLD + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } stateT;

    stateT               state;
    stateT               stateNext;
    logic [HOLD_W-1:0]   holdCnt;
    logic [HOLD_W-1:0]   holdCntNext;
    logic [STARVE_W-1:0] starveCnt;
    logic                lockMeta;
    logic                lockS;
    logic                starved;
    logic                wrGrant;
    logic                rdGrant;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge mainClk or negedge resetN) begin
        if (!resetN) begin
            lockMeta <= 1'b0;
            lockS    <= 1'b0;
        end else begin
            lockMeta <= locked;
            lockS    <= lockMeta;
        end
    end

    // State and hold-counter registers
    always_ff @(posedge mainClk or negedge resetN) begin
        if (!resetN) begin
            state   <= WAIT;
            holdCnt <= '0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdCntNext;
        end
    end

    // Lock qualification: any drop of lockS sends us back to WAIT
    always_comb begin
        stateNext   = state;
        holdCntNext = holdCnt;
        case (state)
            WAIT: begin
                holdCntNext = '0;
                if (lockS) stateNext = HOLD;
            end
            HOLD: begin
                if (!lockS) begin
                    stateNext   = WAIT;
                    holdCntNext = '0;
                end else if (holdCnt == HOLD_W'(LOCK_HOLD)) begin
                    stateNext   = RUN;
                    holdCntNext = '0;
                end else begin
                    holdCntNext = holdCnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!lockS) stateNext = WAIT;
            end
            default: begin
                stateNext   = WAIT;
                holdCntNext = '0;
            end
        endcase
    end

    // Write-priority grant, overridden once the reader has waited STARVE_MAX grants
    always_comb begin
        ready   = 1'b0;
        wrGrant = 1'b0;
        rdGrant = 1'b0;
        starved = (starveCnt == STARVE_W'(STARVE_MAX));
        if (state == RUN) begin
            ready   = 1'b1;
            wrGrant = wrReq & ~(rdReq & starved);
            rdGrant = rdReq & ~wrGrant;
        end
        wrAck = wrGrant;
        rdAck = rdGrant;
    end

    // Count writes granted over a waiting read; any cycle without a read pending clears it
    always_ff @(posedge mainClk or negedge resetN) begin
        if (!resetN) begin
            starveCnt <= '0;
        end else if (!rdReq || rdGrant) begin
            starveCnt <= '0;
        end else if (wrGrant && !starved) begin
            starveCnt <= starveCnt + STARVE_W'(1);
        end
    end

    // Registered RAM command; address and write data hold when idle
    always_ff @(posedge mainClk or negedge resetN) begin
        if (!resetN) begin
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            rdValid  <= 1'b0;
        end else begin
            memEn   <= wrGrant | rdGrant;
            memWe   <= wrGrant;
            rdValid <= memEn & ~memWe;
            if (wrGrant) begin
                memAddr  <= wrAddr;
                memWdata <= wrData;
            end else if (rdGrant) begin
                memAddr <= rdAddr;
            end
        end
    end

    // RAM output already arrives aligned with rdValid
    assign rdData = memRdata;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
module tb_pixel_ram_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LOCK_HOLD  = 8;
    localparam int unsigned STARVE_MAX = 4;

    logic              mainClk = 1'b0;
    logic              resetN  = 1'b1;
    logic              locked  = 1'b0;
    logic              wrReq   = 1'b0;
    logic [ADDR_W-1:0] wrAddr  = '0;
    logic [DATA_W-1:0] wrData  = '0;
    logic              rdReq   = 1'b0;
    logic [ADDR_W-1:0] rdAddr  = '0;
    logic              ready, wrAck, rdAck, rdValid, memEn, memWe;
    logic [DATA_W-1:0] rdData, memWdata, memRdata;
    logic [ADDR_W-1:0] memAddr;

    int checks   = 0;
    int failures = 0;

    pixel_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_HOLD(LOCK_HOLD), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .mainClk(mainClk), .resetN(resetN), .locked(locked), .ready(ready),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(rdAck),
        .rdValid(rdValid), .rdData(rdData),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata)
    );

    always #5 mainClk = ~mainClk;

    // Simple single-port RAM with one cycle read latency
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge mainClk) begin
        if (memEn && memWe) ram[memAddr] <= memWdata;
        if (memEn && !memWe) memRdata <= ram[memAddr];
    end

    function automatic logic [DATA_W-1:0] initPat(input int unsigned a);
        return DATA_W'((a * 37) ^ (a >> 8));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Transaction-level view: memory contents updated at grant time, readiness
    // derived from how long the synchronized lock has been continuously high.
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic              mS1 = 1'b0, mS2 = 1'b0;
    int                streak = 0;
    int                starv  = 0;
    logic              eEn = 1'b0, eWe = 1'b0;
    logic [ADDR_W-1:0] eAddr = '0;
    logic [DATA_W-1:0] eWdata = '0;
    logic              vNow = 1'b0, vNext = 1'b0;
    logic [DATA_W-1:0] dNow = '0, dNext = '0;
    logic              wAckSeen = 1'b0, rAckSeen = 1'b0;

    always @(negedge mainClk) begin : cmpProc
        logic rdyE, gW, gR;
        wAckSeen = wrAck;
        rAckSeen = rdAck;
        if (!resetN) begin
            chk("rstReady", ready, 0);
            chk("rstWrAck", wrAck, 0);
            chk("rstRdAck", rdAck, 0);
            chk("rstMemEn", memEn, 0);
            chk("rstMemWe", memWe, 0);
            chk("rstMemAddr", memAddr, 0);
            chk("rstMemWdata", memWdata, 0);
            chk("rstRdValid", rdValid, 0);
            mS1 = 0; mS2 = 0; streak = 0; starv = 0;
            eEn = 0; eWe = 0; eAddr = '0; eWdata = '0;
            vNow = 0; vNext = 0;
        end else begin
            // Running once lockS has been high for the WAIT->HOLD cycle plus LOCK_HOLD+1 HOLD cycles
            rdyE = (streak >= int'(LOCK_HOLD) + 2);
            gW   = rdyE && wrReq && !(rdReq && starv == int'(STARVE_MAX));
            gR   = rdyE && rdReq && !gW;
            chk("ready", ready, rdyE);
            chk("wrAck", wrAck, gW);
            chk("rdAck", rdAck, gR);
            chk("memEn", memEn, eEn);
            chk("memWe", memWe, eWe);
            chk("memAddr", memAddr, eAddr);
            chk("memWdata", memWdata, eWdata);
            chk("rdValid", rdValid, vNow);
            if (vNow) chk("rdData", rdData, dNow);
            // advance to next cycle
            streak = mS2 ? streak + 1 : 0;
            mS2 = mS1;
            mS1 = locked;
            if (!rdReq || gR) starv = 0;
            else if (gW && starv < int'(STARVE_MAX)) starv++;
            vNow  = vNext;
            dNow  = dNext;
            vNext = gR;
            if (gR) dNext = shadow[rdAddr];
            if (gW) begin
                eEn = 1; eWe = 1; eAddr = wrAddr; eWdata = wrData;
                shadow[wrAddr] = wrData;
            end else if (gR) begin
                eEn = 1; eWe = 0; eAddr = rdAddr;
            end else begin
                eEn = 0; eWe = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge mainClk);
        #2;
    endtask

    // Counts edges after the first edge that samples locked=1 until ready is seen
    task automatic waitReady(output int n);
        n = 99;
        @(posedge mainClk);
        for (int k = 0; k <= 40; k++) begin
            @(negedge mainClk);
            if (ready) begin
                n = k;
                break;
            end
        end
    endtask

    // Lets outstanding requests complete their handshake, then idles both requesters
    task automatic drain();
        for (int k = 0; k < 20 && (wrReq || rdReq); k++) begin
            tick();
            if (wAckSeen) wrReq = 0;
            if (rAckSeen) rdReq = 0;
        end
        chk("drainDone", {31'd0, wrReq | rdReq}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : mainProc
        int n;
        int lastAck;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            ram[a]    = initPat(a);
            shadow[a] = initPat(a);
        end
        #1 resetN = 0;
        repeat (3) tick();
        chk("rstMemEnLit", memEn, 0);
        chk("rstReadyLit", ready, 0);
        resetN = 1;

        // Startup: lock low for 20 cycles, then exact lock-to-ready latency
        repeat (20) tick();
        chk("startReadyLow", ready, 0);
        locked = 1;
        waitReady(n);
        chk("startupLatency", n, 11);

        // Single write then read of the same location
        tick(); wrReq = 1; wrAddr = 16'h0012; wrData = 8'hA5;
        @(negedge mainClk); chk("swWrAck", wrAck, 1);
        tick(); wrReq = 0; rdReq = 1; rdAddr = 16'h0012;
        @(negedge mainClk);
        chk("swMemWe", memWe, 1);
        chk("swMemAddr", memAddr, 32'h0012);
        chk("swMemWdata", memWdata, 32'hA5);
        chk("srRdAck", rdAck, 1);
        tick(); rdReq = 0;
        @(negedge mainClk); chk("srRdValidEarly", rdValid, 0);
        tick();
        @(negedge mainClk);
        chk("srRdValid", rdValid, 1);
        chk("srRdData", rdData, 32'hA5);

        // Contention: both requesting continuously
        tick(); wrReq = 1; rdReq = 1; wrAddr = 16'h0100; wrData = 8'h10; rdAddr = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                tick();
                if (wAckSeen) begin wrAddr = wrAddr + 16'd1; wrData = wrData + 8'd1; end
            end
            @(negedge mainClk);
            chk($sformatf("contGrant%0d", i), {30'd0, wrAck, rdAck}, (i % 5 == 4) ? 32'b01 : 32'b10);
        end
        drain();

        // Read-only streaming from untouched addresses
        for (int k = 0; k < 13; k++) begin
            tick();
            rdReq  = (k < 10);
            rdAddr = ADDR_W'(32'h4000 + k);
            @(negedge mainClk);
            if (k < 10) chk($sformatf("streamAck%0d", k), rdAck, 1);
            if (k >= 2 && k < 12) begin
                chk($sformatf("streamValid%0d", k), rdValid, 1);
                chk($sformatf("streamData%0d", k), rdData, initPat(32'h4000 + k - 2));
            end
            if (k == 12) chk("streamValidEnd", rdValid, 0);
        end

        // Lock loss while a read is in flight
        tick(); rdReq = 1; rdAddr = 16'h0012;
        @(negedge mainClk); chk("llRdAck", rdAck, 1);
        tick(); rdReq = 0; locked = 0; wrReq = 1; wrAddr = 16'h0200; wrData = 8'h3C;
        lastAck = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge mainClk);
            if (wrAck) lastAck = k;
            if (k == 2) begin
                chk("llRdValid", rdValid, 1);
                chk("llRdData", rdData, 32'hA5);
            end
        end
        chk("llAcksStopWithin3", {31'd0, (lastAck >= 1 && lastAck <= 3)}, 1);
        chk("llReadyLow", ready, 0);

        // Relock with a 2-cycle glitch during HOLD: the count restarts
        tick(); locked = 1;
        repeat (6) tick();
        locked = 0;
        repeat (2) tick();
        locked = 1;
        waitReady(n);
        chk("glitchLatency", n, 11);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!wrReq || wAckSeen) begin
                wrReq  = ($urandom_range(0, 9) < 6);
                wrAddr = ADDR_W'($urandom_range(0, 31));
                wrData = DATA_W'($urandom);
            end
            if (!rdReq || rAckSeen) begin
                rdReq  = ($urandom_range(0, 9) < 6);
                rdAddr = ADDR_W'($urandom_range(0, 31));
            end
        end
        drain();

        // Asynchronous reset mid-RUN with a read returning and another issued
        tick(); rdReq = 1; rdAddr = 16'h4000;
        @(negedge mainClk);
        tick(); rdAddr = 16'h4001;
        @(negedge mainClk);
        tick(); rdReq = 0;
        chk("preRstMemEn", memEn, 1);
        chk("preRstRdValid", rdValid, 1);
        #1 resetN = 0;
        #1;
        chk("arMemEn", memEn, 0);
        chk("arMemWe", memWe, 0);
        chk("arRdValid", rdValid, 0);
        chk("arReady", ready, 0);
        chk("arRdAck", rdAck, 0);
        repeat (3) tick();
        resetN = 1;
        waitReady(n);
        chk("rstRelockLatency", n, 11);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_ram_arbiter.md
# pixel_ram_arbiter

Shares the single-port pixel RAM of the neighbourhood processing path between two requesters, all on one clock. The pixel writer stores the incoming camera stream. The window reader fetches neighbourhood pixels for the filter. The block holds off all memory traffic until the clock generator's `locked` is stable, then grants write-priority access with a bounded read-starvation guarantee. It replaces separate write-phase and read-phase clocks with cycle-by-cycle time multiplexing.

## Interface
- `ADDR_W`, 16, pixel RAM address width
- `DATA_W`, 8, pixel width
- `LOCK_HOLD`, 8, consecutive synchronized-`locked` cycles required before access opens (≥1)
- `STARVE_MAX`, 4, max consecutive write grants allowed while `rdReq` is pending (≥1)

- `mainClk` in 1: the only clock
- `resetN` in 1: asynchronous, active-low reset
- `locked` in 1: clock-generator lock, asynchronous to `mainClk`
- `ready` out 1: high while the arbiter is in RUN
- `wrReq` in 1: write request
- `wrAddr` in ADDR_W: write address
- `wrData` in DATA_W: write data
- `wrAck` out 1: write accepted this cycle
- `rdReq` in 1: read request
- `rdAddr` in ADDR_W: read address
- `rdAck` out 1: read accepted this cycle
- `rdValid` out 1: `rdData` valid
- `rdData` out DATA_W: read data
- `memEn` out 1: RAM enable
- `memWe` out 1: RAM write enable
- `memAddr` out ADDR_W: RAM address
- `memWdata` out DATA_W: RAM write data
- `memRdata` in DATA_W: RAM read data, valid 1 cycle after a read command

## Operation
- `locked` passes through a 2-flop synchronizer, giving `lockS`.
- **WAIT**: `ready`=0 and no acks. Moves to HOLD when `lockS`=1.
- **HOLD**: the hold counter increments each cycle that `lockS`=1.
  - `lockS`=0 clears the counter and returns to WAIT.
  - The counter reaching `LOCK_HOLD` moves to RUN.
- **RUN**: `ready`=1. `lockS`=0 returns to WAIT in the next cycle, and acks are blocked from that cycle onward.
- Handshake: each requester holds req, addr and data stable until it sees its ack high at a clock edge. Ack is combinational from state, reqs and the starvation counter. At most one ack is high per cycle.
- Grant rule in RUN:
  - Only `wrReq`: write.
  - Only `rdReq`: read.
  - Both, with the starvation counter < `STARVE_MAX`: write.
  - Both, with the counter = `STARVE_MAX`: read.
- Starvation counter:
  - Increments on a write grant while `rdReq`=1.
  - Clears on any read grant, or in any cycle with `rdReq`=0.
  - Saturates at `STARVE_MAX`.
- On a granted cycle, the next edge registers the memory command:
  - `memEn`=1.
  - `memWe`=1 for a write, 0 for a read.
  - `memAddr` and `memWdata` take the requester's values (`memWdata` is unchanged on a read).
- With no grant, `memEn`=0 and `memWe`=0 at the next edge; `memAddr` and `memWdata` hold.
- Read return: `rdValid` is a registered copy of (`memEn` & !`memWe`). `rdData` = `memRdata`, qualified by `rdValid`.
- Leaving RUN (lock loss) does not cancel an issued read: its `rdValid` still fires.

## Timing
- Reset (`resetN`=0, asynchronous): state=WAIT, synchronizer=0, hold and starvation counters=0.
- Output values during reset: `ready`=0, `wrAck`=0, `rdAck`=0, `memEn`=0, `memWe`=0, `memAddr`=0, `memWdata`=0, `rdValid`=0.
- Reset asserted mid-operation aborts any issued command: `memEn` and `rdValid` drop immediately.
- `locked` rising to the first ack takes 2 synchronizer cycles + 1 WAIT→HOLD cycle + `LOCK_HOLD` HOLD cycles.
- Memory command latency: ack in cycle N; `memEn`/`memWe`/`memAddr` valid in N+1.
- Read data latency: `rdAck` in N; `rdValid`=1 and `rdData` correct in N+2.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed.
- Worst-case read wait with `wrReq` held high: `STARVE_MAX` cycles. The read is granted on cycle `STARVE_MAX`+1.
- `locked` glitches shorter than 1 cycle may be missed. Any `lockS` drop in HOLD restarts the hold count.

## Test plan
- **Startup:** release reset with `locked`=0 for 20 cycles, then raise it, with `LOCK_HOLD`=8.
  - `ready` stays 0 and no acks occur until exactly 11 cycles after the first edge sampling `locked`=1.
  - Pulse `locked` low for 2 cycles during HOLD: the count restarts.
- **Single write, then read:** write addr 0x0012, data 0xA5; then read addr 0x0012 (RAM model has 1-cycle read latency).
  - Write: `memWe`=1 and `memAddr`=0x0012 one cycle after `wrAck`.
  - Read: `rdValid`=1 with `rdData`=0xA5 two cycles after `rdAck`.
- **Contention:** hold `wrReq`=1 and `rdReq`=1 continuously, with `STARVE_MAX`=4.
  - Grant pattern repeats W,W,W,W,R.
  - The starvation counter never exceeds 4.
- **Read-only streaming:** `rdReq`=1 for 10 cycles with incrementing addresses.
  - `rdAck` on every cycle.
  - `rdValid` is high for 10 consecutive cycles, starting 2 cycles after the first ack, with data in address order.
- **Lock loss mid-traffic:** drop `locked` while a read is issued.
  - Acks stop within 3 cycles of the drop.
  - The pending `rdValid` still fires.
  - `ready`=0 until the full hold sequence repeats.
- **Asynchronous reset mid-RUN:** assert `resetN`=0 between clock edges.
  - `memEn`, `memWe`, `rdValid` and `ready` go 0 without waiting for a clock edge.
  - After release, behaviour matches the startup case.
